im_boot_loader: RTL and testbench

Loads a program image into the 256×32 instruction memory from a byte stream, then releases the CPU. Sits between the host/debug byte source, the instruction memory write port and the CPU's stall input. While a load is in progress it owns the memory write port and holds the CPU; otherwise it is idle and the CPU fetches freely.

---
 rtl/im_boot_loader_pkg.sv | 24 ++
 rtl/im_boot_loader_byte_word_packer.sv | 47 ++++
 rtl/im_boot_loader.sv | 158 +++++++++++++++
 tb/tb_im_boot_loader.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/im_boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// im_boot_loader_pkg
// Shared definitions for the instruction-memory boot loader:
//   - loader state encoding
//   - instruction memory geometry (depth, address width, data width)
//   - width of the word counters (must hold the full depth, 1..256)
// -----------------------------------------------------------------------------
package im_boot_loader_pkg;

   localparam int IM_DEPTH = 256;
   localparam int IM_AW    = 8;
   localparam int IM_DW    = 32;

   // One extra bit so a full-depth count (256) is representable.
   localparam int CNT_W    = $clog2(IM_DEPTH) + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HDR   = 2'd1,
      ST_DATA  = 2'd2,
      ST_FLUSH = 2'd3
   } bl_state_e;

endpackage

// File: rtl/im_boot_loader_byte_word_packer.sv
// -----------------------------------------------------------------------------
// im_boot_loader_byte_word_packer
// Assembles big-endian 32-bit words from a byte stream (first byte -> 31:24).
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clr_i            discard any partially assembled word
//   byte_valid_i     a byte is being consumed this cycle
//   byte_i           the byte being consumed
//   word_valid_o     high in the cycle the fourth byte of a word is consumed
//   word_o           {three held bytes, byte_i}; meaningful with word_valid_o
// -----------------------------------------------------------------------------
module im_boot_loader_byte_word_packer
   import im_boot_loader_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             byte_valid_i,
   input  logic [7:0]       byte_i,
   output logic             word_valid_o,
   output logic [IM_DW-1:0] word_o
);

   logic [1:0]       byte_cnt_q;
   logic [IM_DW-9:0] shift_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt_q <= 2'd0;
         shift_q    <= '0;
      end else if (clr_i) begin
         byte_cnt_q <= 2'd0;
         shift_q    <= '0;
      end else if (byte_valid_i) begin
         // The counter wraps 3 -> 0 on word completion; the stale shift
         // contents are fully overwritten by the next three bytes.
         byte_cnt_q <= byte_cnt_q + 2'd1;
         shift_q    <= {shift_q[IM_DW-17:0], byte_i};
      end
   end

   // The fourth byte bypasses the shift register so the word is complete
   // in the same cycle the byte is accepted.
   assign word_valid_o = byte_valid_i && (byte_cnt_q == 2'd3);
   assign word_o       = {shift_q, byte_i};

endmodule

// File: rtl/im_boot_loader.sv
// -----------------------------------------------------------------------------
// im_boot_loader
// Loads a program image from a byte stream into the 256x32 instruction memory
// and holds the CPU while doing so.  Stream format: one header byte
// (word count - 1) followed by 4 bytes per word, big-endian.
// Parameters:
//   BASE_ADDR      word address of the first loaded word
//   HOLD_AT_RESET  keep cpu_hold high out of reset until the first load_done
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   load_start             start a load (honoured only when idle)
//   load_abort             abandon a load in progress
//   s_valid/s_data/s_ready byte stream in (valid/ready handshake)
//   im_we/im_waddr/im_wdata instruction-memory write port (registered)
//   cpu_hold               CPU stall request
//   busy                   loader not idle
//   load_done              one-cycle pulse after the last word is written
//   words_loaded           words written by the current/last load
// -----------------------------------------------------------------------------
module im_boot_loader
   import im_boot_loader_pkg::*;
#(
   parameter logic [IM_AW-1:0] BASE_ADDR     = 8'h00,
   parameter bit               HOLD_AT_RESET = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_start,
   input  logic             load_abort,
   input  logic             s_valid,
   input  logic [7:0]       s_data,
   output logic             s_ready,
   output logic             im_we,
   output logic [IM_AW-1:0] im_waddr,
   output logic [IM_DW-1:0] im_wdata,
   output logic             cpu_hold,
   output logic             busy,
   output logic             load_done,
   output logic [CNT_W-1:0] words_loaded
);

   bl_state_e        state_q, state_d;
   logic             s_ready_q;
   logic             busy_q;
   logic             cpu_hold_q;
   logic             hold_rst_q;     // reset-time hold still pending
   logic             im_we_q;
   logic [IM_AW-1:0] im_waddr_q;
   logic [IM_DW-1:0] im_wdata_q;
   logic             load_done_q;
   logic [CNT_W-1:0] words_loaded_q;
   logic [IM_AW-1:0] ptr_q;
   logic [CNT_W-1:0] remaining_q;

   logic             hdr_accept;
   logic             byte_accept;
   logic             pack_clr;
   logic             done_now;
   logic             word_valid;
   logic [IM_DW-1:0] word;

   // Abort wins over byte acceptance in the same cycle.
   assign hdr_accept  = (state_q == ST_HDR)  && s_valid && !load_abort;
   assign byte_accept = (state_q == ST_DATA) && s_valid && !load_abort;
   // Keep the packer empty while idle so every load starts on a word boundary.
   assign pack_clr    = (state_q == ST_IDLE) || load_abort;
   // An abort during FLUSH suppresses the completion pulse; the write on the
   // bus that cycle still happens since im_we is already registered.
   assign done_now    = (state_q == ST_FLUSH) && !load_abort;

   im_boot_loader_byte_word_packer u_byte_word_packer (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr_i        (pack_clr),
      .byte_valid_i (byte_accept),
      .byte_i       (s_data),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (load_start) state_d = ST_HDR;
         end
         ST_HDR: begin
            if (load_abort)      state_d = ST_IDLE;
            else if (hdr_accept) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (load_abort)
               state_d = ST_IDLE;
            else if (word_valid && (remaining_q == CNT_W'(1)))
               state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         s_ready_q      <= 1'b0;
         busy_q         <= 1'b0;
         cpu_hold_q     <= HOLD_AT_RESET;
         hold_rst_q     <= HOLD_AT_RESET;
         im_we_q        <= 1'b0;
         im_waddr_q     <= BASE_ADDR;
         im_wdata_q     <= '0;
         load_done_q    <= 1'b0;
         words_loaded_q <= '0;
         ptr_q          <= BASE_ADDR;
         remaining_q    <= '0;
      end else begin
         state_q     <= state_d;
         // Status outputs are registered from the next state so they line up
         // with the state register.
         s_ready_q   <= (state_d == ST_HDR) || (state_d == ST_DATA);
         busy_q      <= (state_d != ST_IDLE);
         hold_rst_q  <= hold_rst_q && !done_now;
         cpu_hold_q  <= (state_d != ST_IDLE) || (hold_rst_q && !done_now);
         load_done_q <= done_now;
         im_we_q     <= 1'b0;

         if ((state_q == ST_IDLE) && load_start) begin
            words_loaded_q <= '0;
            ptr_q          <= BASE_ADDR;
         end

         if (hdr_accept) begin
            remaining_q <= CNT_W'(s_data) + CNT_W'(1);
         end

         if (word_valid) begin
            im_we_q        <= 1'b1;
            im_waddr_q     <= ptr_q;
            im_wdata_q     <= word;
            ptr_q          <= ptr_q + IM_AW'(1);   // wraps 0xFF -> 0x00
            remaining_q    <= remaining_q - CNT_W'(1);
            words_loaded_q <= words_loaded_q + CNT_W'(1);
         end
      end
   end

   assign s_ready      = s_ready_q;
   assign busy         = busy_q;
   assign cpu_hold     = cpu_hold_q;
   assign im_we        = im_we_q;
   assign im_waddr     = im_waddr_q;
   assign im_wdata     = im_wdata_q;
   assign load_done    = load_done_q;
   assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_im_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_im_boot_loader
// Two loader instances share one stimulus stream: instance 0 uses the default
// parameters, instance 1 starts at word 0xFE (exercising address wrap) and
// holds the CPU out of reset.  Expected writes are derived from the byte list
// itself: word k = bytes 4k..4k+3 big-endian, at address (base + k) mod 256.
// -----------------------------------------------------------------------------
module tb_im_boot_loader;

   typedef struct {
      int nwords;
      int gap_pct;
      int abort_after;   // data bytes accepted before abort, -1 = none
      bit start_glitch;  // pulse load_start in the middle of DATA
      int exp_words;
      int exp_done;
   } vec_t;

   typedef struct {
      int          dut;
      logic [7:0]  addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_start;
   logic        load_abort;
   logic        s_valid;
   logic [7:0]  s_data;

   logic        s_ready_w     [2];
   logic        im_we_w       [2];
   logic [7:0]  im_waddr_w    [2];
   logic [31:0] im_wdata_w    [2];
   logic        cpu_hold_w    [2];
   logic        busy_w        [2];
   logic        load_done_w   [2];
   logic [8:0]  words_loaded_w[2];

   logic [7:0]  bases [2] = '{8'h00, 8'hFE};
   bit          holds [2] = '{1'b0, 1'b1};
   bit          hold_exp [2];

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          done_total [2] = '{0, 0};
   wr_t         wq [$];
   logic [7:0]  cur_bytes [$];
   vec_t        vecs [7];

   always #5 clk = ~clk;

   im_boot_loader u_dut0 (
      .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_abort(load_abort),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_w[0]),
      .im_we(im_we_w[0]), .im_waddr(im_waddr_w[0]), .im_wdata(im_wdata_w[0]),
      .cpu_hold(cpu_hold_w[0]), .busy(busy_w[0]), .load_done(load_done_w[0]),
      .words_loaded(words_loaded_w[0])
   );

   im_boot_loader #(.BASE_ADDR(8'hFE), .HOLD_AT_RESET(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_abort(load_abort),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_w[1]),
      .im_we(im_we_w[1]), .im_waddr(im_waddr_w[1]), .im_wdata(im_wdata_w[1]),
      .cpu_hold(cpu_hold_w[1]), .busy(busy_w[1]), .load_done(load_done_w[1]),
      .words_loaded(words_loaded_w[1])
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Write / completion monitor, sampled on the falling edge.
   always @(negedge clk) begin
      wr_t w;
      for (int d = 0; d < 2; d++) begin
         if (rst_n === 1'b1 && im_we_w[d] === 1'b1) begin
            w.dut  = d;
            w.addr = im_waddr_w[d];
            w.data = im_wdata_w[d];
            w.cyc  = cyc;
            wq.push_back(w);
         end
         if (load_done_w[d] === 1'b1) done_total[d] <= done_total[d] + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s.d%0d.s_ready", tag, d), s_ready_w[d], 0);
         chk($sformatf("%s.d%0d.im_we", tag, d), im_we_w[d], 0);
         chk($sformatf("%s.d%0d.im_waddr", tag, d), im_waddr_w[d], bases[d]);
         chk($sformatf("%s.d%0d.im_wdata", tag, d), im_wdata_w[d], 0);
         chk($sformatf("%s.d%0d.cpu_hold", tag, d), cpu_hold_w[d], holds[d]);
         chk($sformatf("%s.d%0d.busy", tag, d), busy_w[d], 0);
         chk($sformatf("%s.d%0d.load_done", tag, d), load_done_w[d], 0);
         chk($sformatf("%s.d%0d.words_loaded", tag, d), words_loaded_w[d], 0);
      end
   endtask

   // Present one byte after an optional random gap; wait (bounded) for s_ready.
   task automatic send_byte(input logic [7:0] b, input int gap_pct);
      bit acc;
      for (int g = 0; g < 8; g++) begin
         if ($urandom_range(99) >= gap_pct) break;
         s_valid = 1'b0;
         step();
      end
      s_valid = 1'b1;
      s_data  = b;
      acc     = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) begin
         acc = s_ready_w[0] && s_ready_w[1];
         step();
      end
      chk("byte_accept", acc, 1);
   endtask

   // Runs one load of cur_bytes and checks everything against the byte list.
   task automatic run_load(input string tag, input vec_t v);
      int wbase;
      int dsnap [2];
      int nfull;
      int k;
      int prev;
      bit aborted;
      logic [31:0] exp_data;
      logic [7:0]  exp_addr;

      wbase    = wq.size();
      dsnap[0] = done_total[0];
      dsnap[1] = done_total[1];
      aborted  = 1'b0;

      for (int d = 0; d < 2; d++)
         chk($sformatf("%s.d%0d.idle_hold", tag, d), cpu_hold_w[d], hold_exp[d]);

      load_start = 1'b1;
      step();
      load_start = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s.d%0d.start_ready", tag, d), s_ready_w[d], 1);
         chk($sformatf("%s.d%0d.start_busy", tag, d), busy_w[d], 1);
         chk($sformatf("%s.d%0d.start_hold", tag, d), cpu_hold_w[d], 1);
      end

      send_byte(8'(v.nwords - 1), v.gap_pct);
      for (int i = 0; i < 4 * v.nwords; i++) begin
         if (i == v.abort_after) begin
            aborted = 1'b1;
            break;
         end
         if (v.start_glitch && i == 5) load_start = 1'b1;
         send_byte(cur_bytes[i], v.gap_pct);
         load_start = 1'b0;
      end

      if (aborted) begin
         // Offer a byte in the abort cycle: it must not be taken.
         load_abort = 1'b1;
         s_valid    = 1'b1;
         s_data     = 8'($urandom);
         step();
         load_abort = 1'b0;
         s_valid    = 1'b0;
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s.d%0d.abort_busy", tag, d), busy_w[d], 0);
            chk($sformatf("%s.d%0d.abort_ready", tag, d), s_ready_w[d], 0);
            chk($sformatf("%s.d%0d.abort_hold", tag, d), cpu_hold_w[d], hold_exp[d]);
         end
         step();
         step();
      end else begin
         s_valid = 1'b0;
         // Cycle after the last byte: flush, final write on the bus.
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s.d%0d.flush_we", tag, d), im_we_w[d], 1);
            chk($sformatf("%s.d%0d.flush_busy", tag, d), busy_w[d], 1);
            chk($sformatf("%s.d%0d.flush_ready", tag, d), s_ready_w[d], 0);
            chk($sformatf("%s.d%0d.flush_done", tag, d), load_done_w[d], 0);
         end
         step();
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s.d%0d.done_pulse", tag, d), load_done_w[d], 1);
            chk($sformatf("%s.d%0d.done_hold", tag, d), cpu_hold_w[d], 0);
            chk($sformatf("%s.d%0d.done_busy", tag, d), busy_w[d], 0);
            hold_exp[d] = 1'b0;
         end
         step();
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s.d%0d.done_end", tag, d), load_done_w[d], 0);
            chk($sformatf("%s.d%0d.we_end", tag, d), im_we_w[d], 0);
         end
      end

      nfull = aborted ? (v.abort_after / 4) : v.nwords;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s.d%0d.words_loaded", tag, d), words_loaded_w[d], v.exp_words);
         chk($sformatf("%s.d%0d.done_count", tag, d), done_total[d] - dsnap[d], v.exp_done);
         k    = 0;
         prev = 0;
         for (int j = wbase; j < wq.size(); j++) begin
            if (wq[j].dut == d) begin
               if (k < nfull) begin
                  exp_data = {cur_bytes[4*k], cur_bytes[4*k+1], cur_bytes[4*k+2], cur_bytes[4*k+3]};
                  exp_addr = bases[d] + 8'(k);
                  chk($sformatf("%s.d%0d.w%0d.addr", tag, d, k), wq[j].addr, exp_addr);
                  chk($sformatf("%s.d%0d.w%0d.data", tag, d, k), wq[j].data, exp_data);
                  if (v.gap_pct == 0 && k > 0)
                     chk($sformatf("%s.d%0d.w%0d.spacing", tag, d, k), wq[j].cyc - prev, 4);
               end
               prev = wq[j].cyc;
               k++;
            end
         end
         chk($sformatf("%s.d%0d.write_count", tag, d), k, nfull);
      end
      $display("load %s: nwords=%0d gap=%0d abort_after=%0d words_loaded=%0d/%0d",
               tag, v.nwords, v.gap_pct, v.abort_after, words_loaded_w[0], words_loaded_w[1]);
   endtask

   initial begin
      vec_t        tp;
      int          wb;
      int          n0;
      logic [7:0]  a0 [2];
      logic [31:0] d0 [2];
      logic [7:0]  a1 [2];
      int          n1;

      vecs[0] = '{nwords: 3,   gap_pct: 0,  abort_after: -1, start_glitch: 1'b0, exp_words: 3,   exp_done: 1};
      vecs[1] = '{nwords: 3,   gap_pct: 40, abort_after: -1, start_glitch: 1'b0, exp_words: 3,   exp_done: 1};
      vecs[2] = '{nwords: 4,   gap_pct: 0,  abort_after: 6,  start_glitch: 1'b0, exp_words: 1,   exp_done: 0};
      vecs[3] = '{nwords: 2,   gap_pct: 30, abort_after: -1, start_glitch: 1'b1, exp_words: 2,   exp_done: 1};
      vecs[4] = '{nwords: 1,   gap_pct: 0,  abort_after: -1, start_glitch: 1'b0, exp_words: 1,   exp_done: 1};
      vecs[5] = '{nwords: 5,   gap_pct: 50, abort_after: 12, start_glitch: 1'b0, exp_words: 3,   exp_done: 0};
      vecs[6] = '{nwords: 256, gap_pct: 0,  abort_after: -1, start_glitch: 1'b0, exp_words: 256, exp_done: 1};

      rst_n      = 1'b0;
      load_start = 1'b0;
      load_abort = 1'b0;
      s_valid    = 1'b0;
      s_data     = 8'h00;
      hold_exp   = holds;

      repeat (3) @(posedge clk);
      #1;
      chk_reset("por");
      #2 rst_n = 1'b1;
      step();
      step();
      chk_reset("idle_after_release");

      // Fixed two-word image with literal expected words.
      cur_bytes = {8'h24, 8'h01, 8'h00, 8'h08, 8'h34, 8'h02, 8'h00, 8'h02};
      tp = '{nwords: 2, gap_pct: 0, abort_after: -1, start_glitch: 1'b0, exp_words: 2, exp_done: 1};
      wb = wq.size();
      run_load("fixed2", tp);
      n0 = 0;
      n1 = 0;
      for (int j = wb; j < wq.size(); j++) begin
         if (wq[j].dut == 0 && n0 < 2) begin
            a0[n0] = wq[j].addr;
            d0[n0] = wq[j].data;
            n0++;
         end else if (wq[j].dut == 1 && n1 < 2) begin
            a1[n1] = wq[j].addr;
            n1++;
         end
      end
      chk("fixed2.count0", n0, 2);
      chk("fixed2.count1", n1, 2);
      if (n0 == 2) begin
         chk("fixed2.addr0", a0[0], 8'h00);
         chk("fixed2.data0", d0[0], 32'h24010008);
         chk("fixed2.addr1", a0[1], 8'h01);
         chk("fixed2.data1", d0[1], 32'h34020002);
      end
      if (n1 == 2) begin
         chk("fixed2.base_fe.addr0", a1[0], 8'hFE);
         chk("fixed2.base_fe.addr1", a1[1], 8'hFF);
      end

      // Randomized image table.
      for (int r = 0; r < 7; r++) begin
         cur_bytes.delete();
         for (int i = 0; i < 4 * vecs[r].nwords; i++) cur_bytes.push_back(8'($urandom));
         run_load($sformatf("row%0d", r), vecs[r]);
      end

      // Asynchronous reset in the middle of a load.
      cur_bytes.delete();
      for (int i = 0; i < 12; i++) cur_bytes.push_back(8'($urandom));
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      send_byte(8'd2, 0);
      for (int i = 0; i < 5; i++) send_byte(cur_bytes[i], 0);
      chk("midrst.busy_before", busy_w[0], 1);
      chk("midrst.words_before", words_loaded_w[0], 1);
      #2 rst_n = 1'b0;
      #1;
      chk_reset("midrst");
      s_valid  = 1'b0;
      hold_exp = holds;
      #2 rst_n = 1'b1;
      step();
      chk_reset("midrst_release");

      // Recovery after reset: the reset-time hold must persist until this load completes.
      cur_bytes.delete();
      for (int i = 0; i < 4; i++) cur_bytes.push_back(8'($urandom));
      run_load("post_rst", vecs[4]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
